// File: rtl/ddp_pkg.sv
// Shared definitions for the data-driven pipeline blocks: handshake polarity,
// default token field widths and a constant clog2 helper.
package ddp_pkg;

  localparam bit SEND_ACT = 1'b1;
  localparam bit ACK_ACT  = 1'b1;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_DEST_W = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/ce_fifo.sv
// DEPTH x W synchronous FIFO with wrap-bit pointers; also reports whether it
// will be full after the current edge so the owner can register a ready flag.
module ce_fifo
  import ddp_pkg::*;
#(
  parameter int unsigned W     = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic         CP,
  input  logic         MR,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         full_next
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (do_push) wr_ptr_n = wr_ptr + (AW + 1)'(1);
    if (do_pop)  rd_ptr_n = rd_ptr + (AW + 1)'(1);
  end

  assign full_next = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                     (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
    end
  end

  always_ff @(posedge CP) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ce_route.sv
// Elimination/steering element: buffers kept tokens in a FIFO and routes the
// head to one of N_OUT channels. Define CE_DROP_CNT_EN for the Drop_cnt port.
module ce_route
  import ddp_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned DEST_W = DEF_DEST_W,
  parameter int unsigned DEPTH  = 4
`ifdef CE_DROP_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              Send_in,
  output logic              Ack_out,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              Exb,
  input  logic [DEST_W-1:0] Dest_in,
  output logic [N_OUT-1:0]  Send_out,
  input  logic [N_OUT-1:0]  Ack_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              Empty,
  output logic              Full
`ifdef CE_DROP_CNT_EN
  , output logic [CNT_W-1:0] Drop_cnt
`endif
);

  localparam int unsigned TOK_W = DATA_W + DEST_W;

  logic              accept, keep, pop, full_next;
  logic [TOK_W-1:0]  head;
  logic [DATA_W-1:0] head_data, hold_data;
  logic [DEST_W-1:0] head_dest;

  assign accept = (Send_in == SEND_ACT) && (Ack_out == ACK_ACT);
  assign keep   = Exb && (32'(Dest_in) < N_OUT);

  ce_fifo #(
    .W     (TOK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CP        (CP),
    .MR        (MR),
    .push      (accept && keep),
    .pop       (pop),
    .wdata     ({Data_in, Dest_in}),
    .rdata     (head),
    .full      (Full),
    .empty     (Empty),
    .full_next (full_next)
  );

  assign head_data = head[TOK_W-1:DEST_W];
  assign head_dest = head[DEST_W-1:0];

  // Only the head's own channel can pop it; other Ack_in bits are don't-care.
  always_comb begin
    Send_out = '0;
    pop      = 1'b0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (!Empty && head_dest == DEST_W'(i)) begin
        Send_out[i] = SEND_ACT;
        pop         = (Ack_in[i] == ACK_ACT);
      end
    end
  end

  // Ready is registered from next-state fullness, so Ack_in never reaches Ack_out combinationally.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) Ack_out <= 1'b0;
    else    Ack_out <= !full_next;
  end

  // The FIFO slot behind a popped head is stale, so the last shown value is kept here.
  always_ff @(posedge CP or posedge MR) begin
    if (MR)       hold_data <= '0;
    else if (pop) hold_data <= head_data;
  end

  assign Data_out = Empty ? hold_data : head_data;

`ifdef CE_DROP_CNT_EN
  always_ff @(posedge CP or posedge MR) begin
    if (MR) Drop_cnt <= '0;
    else if (accept && !keep && Drop_cnt != '1) Drop_cnt <= Drop_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_ce_route.sv
// Bench for ce_route (N_OUT=2, DEST_W=2, DEPTH=4) against a queue-based model;
// Drop_cnt is checked when CE_DROP_CNT_EN is defined.
module tb_ce_route;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_OUT  = 2;
  localparam int unsigned DEST_W = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DROP_MAX = 255;
`ifdef CE_DROP_CNT_EN
  localparam int unsigned CNT_W = 8;
`endif

  logic              CP = 1'b0;
  logic              MR;
  logic              Send_in;
  logic              Ack_out;
  logic [DATA_W-1:0] Data_in;
  logic              Exb;
  logic [DEST_W-1:0] Dest_in;
  logic [N_OUT-1:0]  Send_out;
  logic [N_OUT-1:0]  Ack_in;
  logic [DATA_W-1:0] Data_out;
  logic              Empty;
  logic              Full;
`ifdef CE_DROP_CNT_EN
  logic [CNT_W-1:0]  Drop_cnt;
`endif

  always #5 CP = ~CP;

  ce_route #(
    .DATA_W (DATA_W),
    .N_OUT  (N_OUT),
    .DEST_W (DEST_W),
    .DEPTH  (DEPTH)
`ifdef CE_DROP_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .CP       (CP),
    .MR       (MR),
    .Send_in  (Send_in),
    .Ack_out  (Ack_out),
    .Data_in  (Data_in),
    .Exb      (Exb),
    .Dest_in  (Dest_in),
    .Send_out (Send_out),
    .Ack_in   (Ack_in),
    .Data_out (Data_out),
    .Empty    (Empty),
    .Full     (Full)
`ifdef CE_DROP_CNT_EN
    , .Drop_cnt (Drop_cnt)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int unsigned       dest;
  } tok_t;

  tok_t              q[$];
  logic              m_ack;
  logic [DATA_W-1:0] m_last;
  int unsigned       m_drops;
  int                tests = 0;
  int                fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ack   = 1'b0;
    m_last  = '0;
    m_drops = 0;
  endtask

  // One rising edge of the abstract element: pop by head channel, then accept.
  task automatic model_edge();
    bit   acc, pop_h;
    tok_t t;
    acc   = Send_in && m_ack;
    pop_h = (q.size() != 0) && Ack_in[q[0].dest];
    if (pop_h) begin
      m_last = q[0].data;
      void'(q.pop_front());
    end
    if (acc) begin
      if (Exb && int'(Dest_in) < N_OUT) begin
        t.data = Data_in;
        t.dest = int'(Dest_in);
        q.push_back(t);
      end else if (m_drops < DROP_MAX) begin
        m_drops++;
      end
    end
    m_ack = (q.size() < DEPTH);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_send, exp_data;
    exp_send = 32'd0;
    exp_data = 32'(m_last);
    if (q.size() != 0) begin
      exp_send = 32'd1 << q[0].dest;
      exp_data = 32'(q[0].data);
    end
    chk({tag, ".ack"},   32'(Ack_out),  32'(m_ack));
    chk({tag, ".empty"}, 32'(Empty),    32'(q.size() == 0));
    chk({tag, ".full"},  32'(Full),     32'(q.size() == DEPTH));
    chk({tag, ".send"},  32'(Send_out), exp_send);
    chk({tag, ".data"},  32'(Data_out), exp_data);
`ifdef CE_DROP_CNT_EN
    chk({tag, ".drop"},  32'(Drop_cnt), 32'(m_drops));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge CP);
    if (MR) model_reset();
    else    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic s, input logic e, input logic [DEST_W-1:0] d,
                       input logic [DATA_W-1:0] v, input logic [N_OUT-1:0] a);
    Send_in = s;
    Exb     = e;
    Dest_in = d;
    Data_in = v;
    Ack_in  = a;
  endtask

  int unsigned emitted;

  initial begin
    MR = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    model_reset();
    step("reset0");
    step("reset1");
    MR = 1'b0;
    step("release");
    chk("ack_rise", 32'(Ack_out), 32'd1);

    // Single token to channel 1, held while unacknowledged.
    drive(1'b1, 1'b1, 2'd1, 16'h00A5, 2'b00);
    step("a5_push");
    chk("a5_send", 32'(Send_out), 32'h2);
    chk("a5_data", 32'(Data_out), 32'h00A5);
    drive(1'b0, 1'b1, 2'd0, 16'h0000, 2'b00);
    for (int i = 0; i < 5; i++) step("a5_hold");
    Ack_in = 2'b01;
    step("a5_other_ack");
    Ack_in = 2'b10;
    step("a5_pop");
    chk("a5_gone", 32'(Empty), 32'd1);
    Ack_in = 2'b00;

    // Fill to DEPTH, refused fifth, one pop, then fifth accepted.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, DEST_W'(i % 2), DATA_W'(i), 2'b00);
      step("fill");
    end
    chk("fill_full", 32'(Full), 32'd1);
    chk("fill_ack0", 32'(Ack_out), 32'd0);
    drive(1'b1, 1'b1, 2'd1, 16'd5, 2'b00);
    step("fifth_refused");
    Ack_in = 2'b10;
    step("one_pop");
    chk("ack_back", 32'(Ack_out), 32'd1);
    Ack_in = 2'b00;
    step("fifth_accept");
    drive(1'b0, 1'b0, 2'd0, 16'd0, 2'b11);
    for (int i = 0; i < 6; i++) step("drain");

    // Alternating keep bit over ten tokens with free-flowing outputs.
    emitted = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 2 == 0), DEST_W'(i % 2), DATA_W'(16'h0100 + i), 2'b11);
      step("alt");
      if (Send_out != '0) emitted++;
    end
    drive(1'b0, 1'b0, 2'd0, 16'd0, 2'b11);
    for (int i = 0; i < 4; i++) begin
      step("alt_drain");
      if (Send_out != '0) emitted++;
    end
    chk("alt_emitted", emitted, 32'd5);

    // Out-of-range destinations are eliminated.
    drive(1'b1, 1'b1, 2'd2, 16'hBEEF, 2'b11);
    step("dest2");
    chk("dest2_empty", 32'(Empty), 32'd1);
    drive(1'b1, 1'b1, 2'd3, 16'hCAFE, 2'b11);
    step("dest3");

    // Streaming: one token per cycle.
    emitted = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, DEST_W'($urandom_range(0, 1)), DATA_W'($urandom), 2'b11);
      step("stream");
      if (Send_out != '0) emitted++;
    end
    drive(1'b0, 1'b0, 2'd0, 16'd0, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step("stream_drain");
      if (Send_out != '0) emitted++;
    end
    chk("stream_count", emitted, 32'd100);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            DEST_W'($urandom_range(0, 3)), DATA_W'($urandom),
            N_OUT'($urandom_range(0, 3)));
      step("rand");
    end

    // Enough eliminations to saturate the counter.
    drive(1'b1, 1'b0, 2'd0, 16'h1234, 2'b11);
    for (int i = 0; i < 300; i++) step("sat");
`ifdef CE_DROP_CNT_EN
    chk("sat_ff", 32'(Drop_cnt), 32'hFF);
`endif

    // Asynchronous reset mid-cycle with three tokens queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, DEST_W'(i % 2), DATA_W'(16'h0E00 + i), 2'b00);
      step("q3");
    end
    drive(1'b0, 1'b0, 2'd0, 16'd0, 2'b00);
    #2;
    MR = 1'b1;
    #1;
    model_reset();
    check_all("mr_async");
    chk("mr_send0", 32'(Send_out), 32'd0);
    step("mr_held");
    MR = 1'b0;
    step("mr_release");
    chk("mr_ack1", 32'(Ack_out), 32'd1);
    Ack_in = 2'b11;
    for (int i = 0; i < 4; i++) step("mr_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
